// File: rtl/nfu_2b_accum.sv
// NFU-2B: registered binary adder tree over Tn masked signed lanes, followed by
// a saturating group accumulator that emits one clipped result per group.
module nfu_2b_accum #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int LOG2_TN   = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Tn*BIT_WIDTH-1:0] i_nfu2A,
  input  logic [Tn-1:0]           i_lane_en,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  output logic [BIT_WIDTH-1:0]    o_nfu2B,
  output logic                    o_valid,
  output logic                    o_sat,
  output logic                    o_busy
);

  localparam int TW = BIT_WIDTH + LOG2_TN;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0]        OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0]        OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic [LOG2_TN:0] stage_vld;

  // Stage 0 captures the masked lanes; stage s holds Tn>>s sums of width BIT_WIDTH+s.
  for (genvar s = 0; s <= LOG2_TN; s++) begin : g_st
    localparam int unsigned N = Tn >> s;
    localparam int          W = BIT_WIDTH + s;

    logic signed [W-1:0] sum_q [N];
    logic                vld_q, fst_q, lst_q;

    assign stage_vld[s] = vld_q;

    if (s == 0) begin : g_cap
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < N; k++) sum_q[k] <= '0;
          vld_q <= 1'b0;
          fst_q <= 1'b0;
          lst_q <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < N; k++)
            sum_q[k] <= i_lane_en[k] ? i_nfu2A[k*BIT_WIDTH +: BIT_WIDTH] : '0;
          vld_q <= i_valid;
          fst_q <= i_valid & i_first;
          lst_q <= i_valid & i_last;
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < N; k++) sum_q[k] <= '0;
          vld_q <= 1'b0;
          fst_q <= 1'b0;
          lst_q <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < N; k++)
            sum_q[k] <= {g_st[s-1].sum_q[2*k][W-2],   g_st[s-1].sum_q[2*k]}
                      + {g_st[s-1].sum_q[2*k+1][W-2], g_st[s-1].sum_q[2*k+1]};
          vld_q <= g_st[s-1].vld_q;
          fst_q <= g_st[s-1].fst_q;
          lst_q <= g_st[s-1].lst_q;
        end
      end
    end
  end

  logic signed [TW-1:0]        tree_sum;
  logic                        tree_vld, tree_fst, tree_lst;
  logic signed [ACC_WIDTH-1:0] tree_ext;
  logic        [ACC_WIDTH:0]   acc_wide;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sticky_q, sticky_d;
  logic                        open_q, open_d;
  logic [BIT_WIDTH-1:0]        res_d;
  logic                        sat_d, vld_d, clip;

  assign tree_sum = g_st[LOG2_TN].sum_q[0];
  assign tree_vld = g_st[LOG2_TN].vld_q;
  assign tree_fst = g_st[LOG2_TN].fst_q;
  assign tree_lst = g_st[LOG2_TN].lst_q;
  assign tree_ext = {{(ACC_WIDTH-TW){tree_sum[TW-1]}}, tree_sum};
  assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + {tree_ext[ACC_WIDTH-1], tree_ext};

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    open_d   = open_q;
    res_d    = o_nfu2B;
    sat_d    = o_sat;
    vld_d    = 1'b0;
    clip     = 1'b0;
    if (tree_vld) begin
      if (tree_fst) begin
        acc_d    = tree_ext;
        sticky_d = 1'b0;
      end else if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
        acc_d    = acc_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        sticky_d = 1'b1;
      end else begin
        acc_d    = acc_wide[ACC_WIDTH-1:0];
      end
      open_d = ~tree_lst;
      if (tree_lst) begin
        // Value fits the output only if all bits above the output sign bit agree with it.
        clip  = (acc_d[ACC_WIDTH-1:BIT_WIDTH-1] != '0) &&
                (acc_d[ACC_WIDTH-1:BIT_WIDTH-1] != '1);
        res_d = clip ? (acc_d[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX) : acc_d[BIT_WIDTH-1:0];
        sat_d = sticky_d | clip;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      open_q   <= 1'b0;
      o_nfu2B  <= '0;
      o_sat    <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      open_q   <= open_d;
      o_nfu2B  <= res_d;
      o_sat    <= sat_d;
      o_valid  <= vld_d;
    end
  end

  assign o_busy = (|stage_vld) | open_q;

endmodule

// File: tb/tb_nfu_2b_accum.sv
// Directed bench for nfu_2b_accum: a group-level arithmetic model predicts each
// result and its due cycle; a negedge process checks every cycle against it.
module tb_nfu_2b_accum;
  localparam int BW = 16;
  localparam int TN = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [TN*BW-1:0]  i_nfu2A = '0;
  logic [TN-1:0]     i_lane_en = '0;
  logic              i_valid = 1'b0;
  logic              i_first = 1'b0;
  logic              i_last = 1'b0;
  logic [BW-1:0]     o_nfu2B;
  logic              o_valid, o_sat, o_busy;

  nfu_2b_accum #(.BIT_WIDTH(16), .Tn(16), .LOG2_TN(4), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_nfu2A(i_nfu2A), .i_lane_en(i_lane_en),
    .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .o_nfu2B(o_nfu2B), .o_valid(o_valid), .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] d; logic s; } exp_t;
  exp_t   q[$];
  longint macc = 0;
  logic   msticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [TN*BW-1:0] fill(input int v);
    logic [TN*BW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*BW +: BW] = v[BW-1:0];
    return r;
  endfunction

  // Group arithmetic: exact beat sum, 32-bit saturating accumulate, 16-bit output clip.
  task automatic model_beat(input logic [TN*BW-1:0] d, input logic [TN-1:0] en,
                            input logic f, input logic l);
    longint s = 0;
    longint o;
    logic   c = 1'b0;
    for (int k = 0; k < TN; k++)
      if (en[k]) s += longint'($signed(d[k*BW +: BW]));
    if (f) begin
      macc = s;
      msticky = 1'b0;
    end else begin
      macc += s;
      if (macc > 64'sd2147483647) begin macc = 64'sd2147483647; msticky = 1'b1; end
      else if (macc < -64'sd2147483648) begin macc = -64'sd2147483648; msticky = 1'b1; end
    end
    if (l) begin
      o = macc;
      if (o > 32767) begin o = 32767; c = 1'b1; end
      else if (o < -32768) begin o = -32768; c = 1'b1; end
      q.push_back('{cyc + 6, o[15:0], msticky | c});
    end
  endtask

  task automatic beat(input logic [TN*BW-1:0] d, input logic [TN-1:0] en,
                      input logic f, input logic l);
    i_nfu2A = d; i_lane_en = en; i_valid = 1'b1; i_first = f; i_last = l;
    model_beat(d, en, f, l);
    @(negedge clk);
  endtask

  task automatic idle();
    i_valid = 1'b0; i_first = 1'b1; i_last = 1'b1; i_nfu2A = fill(7);
    @(negedge clk);
  endtask

  task automatic wait_result(input string name, input logic [15:0] ed, input logic es);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin found = 1'b1; break; end
    end
    chk({name, "_seen"}, {31'b0, found}, 32'd1);
    if (found) begin
      chk({name, "_data"}, {16'b0, o_nfu2B}, {16'b0, ed});
      chk({name, "_sat"}, {31'b0, o_sat}, {31'b0, es});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("o_valid", {31'b0, o_valid}, {31'b0, ev});
      if (ev) begin
        chk("model_data", {16'b0, o_nfu2B}, {16'b0, q[0].d});
        chk("model_sat", {31'b0, o_sat}, {31'b0, q[0].s});
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [TN*BW-1:0] dv;
    logic [15:0]      t;

    #1;
    chk("rst_data", {16'b0, o_nfu2B}, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_sat", {31'b0, o_sat}, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle();

    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    idle();
    wait_result("single", 16'd16, 1'b0);

    beat(fill(2), 16'hFFFF, 1'b1, 1'b0);
    beat(fill(3), 16'hFFFF, 1'b0, 1'b0);
    idle();
    beat(fill(-1), 16'hFFFF, 1'b0, 1'b1);
    idle();
    wait_result("multi", 16'd64, 1'b0);
    @(negedge clk);
    chk("multi_busy_after", {31'b0, o_busy}, 32'd0);

    for (int k = 0; k < TN; k++) begin
      t = 16'(k - 8);
      dv[k*BW +: BW] = t;
    end
    beat(dv, 16'h00FF, 1'b1, 1'b1);
    idle();
    wait_result("mask", 16'hFFDC, 1'b0);

    beat(fill(32'h7FFF), 16'hFFFF, 1'b1, 1'b0);
    beat(fill(32'h7FFF), 16'hFFFF, 1'b0, 1'b0);
    beat(fill(32'h7FFF), 16'hFFFF, 1'b0, 1'b0);
    beat(fill(32'h7FFF), 16'hFFFF, 1'b0, 1'b1);
    idle();
    wait_result("outsat", 16'h7FFF, 1'b1);
    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    idle();
    wait_result("after_sat", 16'd16, 1'b0);

    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    beat(fill(2), 16'hFFFF, 1'b1, 1'b1);
    idle();
    wait_result("b2b_a", 16'd16, 1'b0);
    wait_result("b2b_b", 16'd32, 1'b0);

    beat(fill(5), 16'hFFFF, 1'b1, 1'b0);
    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    idle();
    wait_result("restart", 16'd16, 1'b0);
    repeat (3) idle();

    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    idle();
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    macc = 0;
    msticky = 1'b0;
    #1;
    chk("arst_data", {16'b0, o_nfu2B}, 32'd0);
    chk("arst_valid", {31'b0, o_valid}, 32'd0);
    chk("arst_sat", {31'b0, o_sat}, 32'd0);
    chk("arst_busy", {31'b0, o_busy}, 32'd0);
    i_valid = 1'b1; i_first = 1'b1; i_last = 1'b1; i_nfu2A = fill(9);
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b0;
    repeat (8) idle();
    chk("post_rst_busy", {31'b0, o_busy}, 32'd0);
    beat(fill(1), 16'hFFFF, 1'b1, 1'b1);
    idle();
    wait_result("post_rst", 16'd16, 1'b0);

    repeat (8) idle();
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
